two_power_log: RTL and testbench

//  Inverse of the modular power-of-two unit: given target t and modulus m, finds the smallest
//  k in [0, limit] with 2^k mod m == t (discrete log base 2). Iterative, one candidate per cycle.

---
 rtl/two_power_log.sv | 148 ++++++++++++++
 tb/tb_two_power_log.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/two_power_log.sv
// Iterative discrete log base 2: finds the smallest k in [0, limit] with 2^k mod m == t,
// trying one candidate exponent per cycle behind a valid/ready request/result handshake.
module two_power_log #(
    parameter int unsigned MOD_WIDTH = 32,
    parameter int unsigned POW_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_target,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    input  logic [POW_WIDTH-1:0] i_limit,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [POW_WIDTH-1:0] o_power,
    output logic                 o_found,
    output logic                 o_error
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [MOD_WIDTH:0]   ResOne = {{MOD_WIDTH{1'b0}}, 1'b1};
    localparam logic [POW_WIDTH-1:0] PowOne = {{(POW_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [POW_WIDTH-1:0] k_q, k_d;
    logic [MOD_WIDTH:0]   r_q, r_d;
    logic [MOD_WIDTH-1:0] t_q, t_d;
    logic [MOD_WIDTH-1:0] m_q, m_d;
    logic [POW_WIDTH-1:0] limit_q, limit_d;
    logic [POW_WIDTH-1:0] power_q, power_d;
    logic                 found_q, found_d;
    logic                 error_q, error_d;

    logic [MOD_WIDTH:0] r_dbl;
    logic [MOD_WIDTH:0] m_ext;
    logic [MOD_WIDTH:0] r_step;
    logic               req_bad;
    logic               hit_target;
    logic               cycle_closed;
    logic               at_limit;

    // r < m holds in RUN, so doubling fits in MOD_WIDTH+1 bits and one subtract reduces it.
    always_comb begin
        r_dbl  = {r_q[MOD_WIDTH-1:0], 1'b0};
        m_ext  = {1'b0, m_q};
        r_step = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;
    end

    always_comb begin
        req_bad      = (i_modulus[MOD_WIDTH-1:1] == '0) || (i_target >= i_modulus);
        hit_target   = (r_q == {1'b0, t_q});
        cycle_closed = (k_q != '0) && (r_q == ResOne);
        at_limit     = (k_q == limit_q);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        t_d     = t_q;
        m_d     = m_q;
        limit_d = limit_q;
        power_d = power_q;
        found_d = found_q;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    t_d     = i_target;
                    m_d     = i_modulus;
                    limit_d = i_limit;
                    k_d     = '0;
                    r_d     = ResOne;
                    found_d = 1'b0;
                    if (req_bad) begin
                        state_d = StDone;
                        error_d = 1'b1;
                        power_d = '0;
                    end else begin
                        state_d = StRun;
                        error_d = 1'b0;
                    end
                end
            end
            StRun: begin
                if (hit_target) begin
                    state_d = StDone;
                    found_d = 1'b1;
                    power_d = k_q;
                end else if (cycle_closed || at_limit) begin
                    // Residues have started repeating, or the budget is spent.
                    state_d = StDone;
                    found_d = 1'b0;
                    power_d = k_q;
                end else begin
                    k_d = k_q + PowOne;
                    r_d = r_step;
                end
            end
            StDone: begin
                if (o_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            m_q     <= '0;
            limit_q <= '0;
            power_q <= '0;
            found_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            t_q     <= t_d;
            m_q     <= m_d;
            limit_q <= limit_d;
            power_q <= power_d;
            found_q <= found_d;
            error_q <= error_d;
        end
    end

    assign i_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_power = power_q;
    assign o_found = found_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_two_power_log.sv
// Self-checking bench for two_power_log: directed corner cases plus randomized requests
// checked against an arithmetic discrete-log reference model.
module tb_two_power_log;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_target;
    logic [31:0] i_modulus;
    logic [31:0] i_limit;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_power;
    logic        o_found;
    logic        o_error;

    int n_checks = 0;
    int n_pass   = 0;

    two_power_log #(
        .MOD_WIDTH(32),
        .POW_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_target (i_target),
        .i_modulus(i_modulus),
        .i_limit  (i_limit),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_power  (o_power),
        .o_found  (o_found),
        .o_error  (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Walk 2^k mod m directly; lat is posedges after the accept edge until o_valid.
    task automatic model(input longint unsigned t, input longint unsigned m,
                         input longint unsigned limit, output bit found,
                         output longint unsigned power, output bit error, output int lat);
        longint unsigned r;
        found = 0;
        power = 0;
        error = 0;
        lat   = 0;
        if (m < 2 || t >= m) begin
            error = 1;
            return;
        end
        r = 1;
        for (longint unsigned k = 0; ; k++) begin
            if (r == t) begin
                found = 1;
                power = k;
                lat   = int'(k) + 1;
                return;
            end
            if ((k != 0 && r == 1) || k == limit) begin
                power = k;
                lat   = int'(k) + 1;
                return;
            end
            r = (2 * r) % m;
        end
    endtask

    task automatic run_req(input logic [31:0] t, input logic [31:0] m, input logic [31:0] lim,
                           input int hold);
        bit              e_found;
        bit              e_error;
        longint unsigned e_power;
        int              e_lat;
        int              lat;
        model(t, m, lim, e_found, e_power, e_error, e_lat);
        @(negedge clk);
        check("i_ready_before_accept", i_ready, 1);
        i_valid   = 1'b1;
        i_target  = t;
        i_modulus = m;
        i_limit   = lim;
        @(negedge clk);
        i_valid   = 1'b0;
        i_target  = $urandom;
        i_modulus = $urandom;
        i_limit   = $urandom;
        lat = 0;
        while (!o_valid && lat <= e_lat + 4) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e_lat);
        check("o_valid", o_valid, 1);
        check("o_found", o_found, e_found);
        check("o_error", o_error, e_error);
        check("o_power", o_power, e_power);
        check("i_ready_in_done", i_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_o_valid", o_valid, 1);
            check("hold_o_power", o_power, e_power);
            check("hold_o_found", o_found, e_found);
            check("hold_o_error", o_error, e_error);
            check("hold_i_ready", i_ready, 0);
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        check("o_valid_after_handshake", o_valid, 0);
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] t;
        logic [31:0] lim;

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_target  = '0;
        i_modulus = '0;
        i_limit   = '0;
        o_ready   = 1'b0;
        #12;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_power", o_power, 0);
        check("reset_o_found", o_found, 0);
        check("reset_o_error", o_error, 0);
        check("reset_i_ready", i_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(3, 11, 100, 0);
        run_req(3, 7, 100, 0);
        run_req(3, 11, 5, 0);
        run_req(8, 12, 100, 0);
        run_req(1, 11, 100, 0);
        run_req(0, 1, 100, 0);
        run_req(7, 5, 100, 0);
        run_req(5, 11, 0, 0);
        run_req(1, 2, 0, 0);
        run_req(0, 2, 50, 0);
        run_req(3, 11, 8, 10);
        run_req(9, 11, 100, 0);

        // Abort a search with reset and confirm the block recovers cleanly.
        @(negedge clk);
        i_valid   = 1'b1;
        i_target  = 3;
        i_modulus = 11;
        i_limit   = 100;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_o_valid", o_valid, 0);
        check("midrun_reset_i_ready", i_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_reset_o_valid", o_valid, 0);
        check("post_reset_i_ready", i_ready, 1);
        run_req(3, 11, 100, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) m = $urandom;
            else m = $urandom_range(0, 400);
            if (m > 1 && $urandom_range(0, 5) != 0) t = $urandom_range(0, m - 1);
            else t = $urandom_range(0, 500);
            lim = $urandom_range(0, 300);
            run_req(t, m, lim, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
